esm_issue_scheduler: RTL and testbench

Issue stage directly downstream of the ESM dependency-analysis stage, and the owner of the instruction buffer slots. It allocates a free buffer slot, which drives the analyser's buffer_index. It latches the dependency row the analyser produces for that slot, tracks per-slot state and relative age, and issues the oldest dependency-free instruction to execution over a valid/ready handshake. Completion broadcasts free slots and clear the matching dependency columns.

---
 rtl/esm_issue_scheduler_if.sv | 28 ++
 rtl/esm_issue_scheduler.sv | 152 +++++++++++++++
 tb/tb_esm_issue_scheduler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/esm_issue_scheduler_if.sv
// Handshake bundle between the ESM dependency analyser, the issue scheduler and execution.
// The scheduler side uses the slave modport.
interface esm_issue_scheduler_if #(
    parameter int bs = 16
);
    localparam int IW = $clog2(bs);

    logic          alloc_valid;
    logic [bs-1:0] alloc_deps;
    logic          alloc_ready;
    logic [IW-1:0] alloc_index;
    logic          issue_valid;
    logic [IW-1:0] issue_index;
    logic          issue_ready;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic [IW:0]   occupancy;

    modport master (
        output alloc_valid, alloc_deps, issue_ready, complete_valid, complete_index,
        input  alloc_ready, alloc_index, issue_valid, issue_index, occupancy
    );

    modport slave (
        input  alloc_valid, alloc_deps, issue_ready, complete_valid, complete_index,
        output alloc_ready, alloc_index, issue_valid, issue_index, occupancy
    );
endinterface

// File: rtl/esm_issue_scheduler.sv
// Issue scheduler: owns the instruction buffer slots and tracks their dependencies and
// relative age. It issues the oldest dependency-free slot and frees slots on completion.
module esm_issue_scheduler #(
    parameter int bs = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    esm_issue_scheduler_if.slave  sif
);
    localparam int          IW      = $clog2(bs);
    localparam logic [IW:0] OCC_ONE = {{IW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WAITING = 2'd1,
        SLOT_ISSUED  = 2'd2
    } slot_state_e;

    slot_state_e   state_r   [bs];
    slot_state_e   state_n_s [bs];
    logic [bs-1:0] dep_r     [bs];
    logic [bs-1:0] dep_n_s   [bs];
    logic [bs-1:0] older_r   [bs];
    logic [bs-1:0] older_n_s [bs];
    logic [IW:0]   occ_r;
    logic [IW:0]   occ_n_s;

    logic [bs-1:0] nonfree_s;
    logic [bs-1:0] ready_s;
    logic [bs-1:0] oldest_s;
    logic [bs-1:0] alloc_mask_s;
    logic [bs-1:0] comp_mask_s;
    logic          alloc_ready_s;
    logic          alloc_fire_s;
    logic          issue_valid_s;
    logic          issue_fire_s;
    logic          comp_fire_s;
    logic [IW-1:0] alloc_index_s;
    logic [IW-1:0] issue_index_s;

    // Slot classification: occupied slots and slots whose dependencies have all drained
    always_comb begin
        nonfree_s = {bs{1'b0}};
        ready_s   = {bs{1'b0}};
        for (int i = 0; i < bs; i++) begin
            nonfree_s[i] = (state_r[i] != SLOT_FREE);
            ready_s[i]   = (state_r[i] == SLOT_WAITING) && (dep_r[i] == {bs{1'b0}});
        end
    end

    // Lowest-numbered free slot; the descending scan leaves the lowest hit last
    always_comb begin
        alloc_index_s = {IW{1'b0}};
        alloc_mask_s  = {bs{1'b0}};
        for (int i = bs - 1; i >= 0; i--) begin
            if (!nonfree_s[i]) begin
                alloc_index_s   = IW'(i);
                alloc_mask_s    = {bs{1'b0}};
                alloc_mask_s[i] = 1'b1;
            end else begin
                alloc_index_s = alloc_index_s;
            end
        end
        alloc_ready_s = ~(&nonfree_s);
    end

    // Oldest ready slot: ready and no other ready slot is recorded as older than it
    always_comb begin
        oldest_s      = {bs{1'b0}};
        issue_index_s = {IW{1'b0}};
        for (int i = 0; i < bs; i++) begin
            oldest_s[i] = ready_s[i] && ((older_r[i] & ready_s) == {bs{1'b0}});
        end
        for (int i = bs - 1; i >= 0; i--) begin
            if (oldest_s[i]) begin
                issue_index_s = IW'(i);
            end else begin
                issue_index_s = issue_index_s;
            end
        end
        issue_valid_s = |ready_s;
    end

    // Qualified events; a completion only counts against an ISSUED slot
    always_comb begin
        alloc_fire_s = sif.alloc_valid && alloc_ready_s;
        issue_fire_s = issue_valid_s && sif.issue_ready;
        comp_fire_s  = 1'b0;
        comp_mask_s  = {bs{1'b0}};
        for (int i = 0; i < bs; i++) begin
            if (sif.complete_valid && (sif.complete_index == IW'(i)) &&
                (state_r[i] == SLOT_ISSUED)) begin
                comp_fire_s    = 1'b1;
                comp_mask_s[i] = 1'b1;
            end else begin
                comp_mask_s[i] = 1'b0;
            end
        end
    end

    // Next slot state, dependency and age matrices, and occupancy
    always_comb begin
        for (int i = 0; i < bs; i++) begin
            state_n_s[i] = state_r[i];
            dep_n_s[i]   = dep_r[i] & ~comp_mask_s;
            older_n_s[i] = older_r[i] & ~comp_mask_s;
            if (comp_mask_s[i]) begin
                state_n_s[i] = SLOT_FREE;
                older_n_s[i] = {bs{1'b0}};
            end else if (alloc_fire_s && alloc_mask_s[i]) begin
                state_n_s[i] = SLOT_WAITING;
                dep_n_s[i]   = sif.alloc_deps & nonfree_s & ~alloc_mask_s & ~comp_mask_s;
                // A slot freed this cycle must not linger as "older" once it is reused
                older_n_s[i] = nonfree_s & ~comp_mask_s;
            end else if (issue_fire_s && (issue_index_s == IW'(i))) begin
                state_n_s[i] = SLOT_ISSUED;
            end else begin
                state_n_s[i] = state_r[i];
            end
        end
        case ({alloc_fire_s, comp_fire_s})
            2'b10:   occ_n_s = occ_r + OCC_ONE;
            2'b01:   occ_n_s = occ_r - OCC_ONE;
            default: occ_n_s = occ_r;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < bs; i++) begin
                state_r[i] <= SLOT_FREE;
                dep_r[i]   <= {bs{1'b0}};
                older_r[i] <= {bs{1'b0}};
            end
            occ_r <= {(IW + 1){1'b0}};
        end else begin
            for (int i = 0; i < bs; i++) begin
                state_r[i] <= state_n_s[i];
                dep_r[i]   <= dep_n_s[i];
                older_r[i] <= older_n_s[i];
            end
            occ_r <= occ_n_s;
        end
    end

    assign sif.alloc_ready = alloc_ready_s;
    assign sif.alloc_index = alloc_index_s;
    assign sif.issue_valid = issue_valid_s;
    assign sif.issue_index = issue_index_s;
    assign sif.occupancy   = occ_r;
endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Directed bench for esm_issue_scheduler: expected issue order is queued by the stimulus
// and popped by a monitor on every issue handshake; status outputs are checked directly.
module tb_esm_issue_scheduler;
    localparam int BS = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    esm_issue_scheduler_if #(.bs(BS)) sif ();
    esm_issue_scheduler #(.bs(BS)) dut (.clk(clk), .rst(rst), .sif(sif));

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [BS-1:0] deps);
        sif.alloc_valid = 1'b1;
        sif.alloc_deps  = deps;
        tick();
        sif.alloc_valid = 1'b0;
        sif.alloc_deps  = 16'h0000;
    endtask

    task automatic complete(input int idx);
        sif.complete_valid = 1'b1;
        sif.complete_index = 4'(idx);
        tick();
        sif.complete_valid = 1'b0;
        sif.complete_index = 4'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_alloc_ready"}, int'(sif.alloc_ready), 1);
        check({tag, "_alloc_index"}, int'(sif.alloc_index), 0);
        check({tag, "_issue_valid"}, int'(sif.issue_valid), 0);
        check({tag, "_issue_index"}, int'(sif.issue_index), 0);
        check({tag, "_occupancy"},   int'(sif.occupancy),   0);
    endtask

    // Issue monitor: every handshake must match the next queued slot index
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst && sif.issue_valid && sif.issue_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected actual=%0d required=none", sif.issue_index);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_order", int'(sif.issue_index), e);
                end
            end
        end
    end

    initial begin
        rst                = 1'b1;
        sif.alloc_valid    = 1'b0;
        sif.alloc_deps     = 16'h0000;
        sif.issue_ready    = 1'b0;
        sif.complete_valid = 1'b0;
        sif.complete_index = 4'd0;
        tick();
        tick();
        rst = 1'b0;

        // 1: reset values, then reset after five entries (alloc held high during reset)
        check_reset_state("rst0");
        repeat (5) alloc(16'h0000);
        check("load5_occupancy",   int'(sif.occupancy),   5);
        check("load5_alloc_index", int'(sif.alloc_index), 5);
        check("load5_issue_valid", int'(sif.issue_valid), 1);
        check("load5_issue_index", int'(sif.issue_index), 0);
        rst = 1'b1;
        sif.alloc_valid = 1'b1;
        tick();
        rst = 1'b0;
        sif.alloc_valid = 1'b0;
        check_reset_state("rst1");

        // 2: dependency chain slot1 -> slot0
        sif.issue_ready = 1'b1;
        exp_q.push_back(0);
        alloc(16'h0000);
        alloc(16'h0001);
        check("dep_blocked_valid", int'(sif.issue_valid), 0);
        check("dep_occupancy",     int'(sif.occupancy),   2);
        check("dep_alloc_index",   int'(sif.alloc_index), 2);
        tick();
        check("dep_still_blocked", int'(sif.issue_valid), 0);
        exp_q.push_back(1);
        complete(0);
        check("dep_wake_valid",  int'(sif.issue_valid), 1);
        check("dep_wake_index",  int'(sif.issue_index), 1);
        check("dep_freed_index", int'(sif.alloc_index), 0);
        check("dep_occ_after",   int'(sif.occupancy),   1);
        tick();
        complete(1);
        check("dep_drained_occ", int'(sif.occupancy), 0);
        sif.issue_ready = 1'b0;

        // 3: age order after slot0 is reused
        alloc(16'h0000);
        alloc(16'h0000);
        check("age_first_index", int'(sif.issue_index), 0);
        exp_q.push_back(0);
        sif.issue_ready = 1'b1;
        tick();
        sif.issue_ready = 1'b0;
        complete(0);
        check("age_realloc_index", int'(sif.alloc_index), 0);
        alloc(16'h0000);
        check("age_oldest_is_1", int'(sif.issue_index), 1);
        exp_q.push_back(1);
        exp_q.push_back(0);
        sif.issue_ready = 1'b1;
        tick();
        tick();
        sif.issue_ready = 1'b0;
        check("age_all_issued", int'(sif.issue_valid), 0);
        complete(1);
        complete(0);
        check("age_drained_occ", int'(sif.occupancy), 0);

        // 4: full buffer, ignored extra alloc, slot 9 freed
        repeat (BS) alloc(16'h0000);
        check("full_alloc_ready", int'(sif.alloc_ready), 0);
        check("full_occupancy",   int'(sif.occupancy),   16);
        alloc(16'h0000);
        check("full_ignored_occ", int'(sif.occupancy),   16);
        for (int i = 0; i < 10; i++) exp_q.push_back(i);
        sif.issue_ready = 1'b1;
        repeat (10) tick();
        sif.issue_ready = 1'b0;
        check("full_next_index", int'(sif.issue_index), 10);
        complete(9);
        check("free9_alloc_ready", int'(sif.alloc_ready), 1);
        check("free9_alloc_index", int'(sif.alloc_index), 9);
        check("free9_occupancy",   int'(sif.occupancy),   15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst2");

        // 5: dependency on a FREE slot is dropped
        sif.issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        alloc(16'h0000);
        alloc(16'h0000);
        alloc(16'h0000);
        alloc(16'h0100);
        check("stale_valid", int'(sif.issue_valid), 1);
        check("stale_index", int'(sif.issue_index), 3);
        tick();
        sif.issue_ready = 1'b0;
        check("stale_all_issued", int'(sif.issue_valid), 0);
        check("stale_occupancy",  int'(sif.occupancy),   4);

        // 6: same-cycle alloc on slot2 completion, ignored completion of a WAITING slot
        sif.alloc_valid    = 1'b1;
        sif.alloc_deps     = 16'h0004;
        sif.complete_valid = 1'b1;
        sif.complete_index = 4'd2;
        tick();
        sif.alloc_valid    = 1'b0;
        sif.alloc_deps     = 16'h0000;
        sif.complete_valid = 1'b0;
        sif.complete_index = 4'd0;
        check("same_valid",       int'(sif.issue_valid), 1);
        check("same_index",       int'(sif.issue_index), 4);
        check("same_alloc_index", int'(sif.alloc_index), 2);
        check("same_occupancy",   int'(sif.occupancy),   4);
        complete(4);
        check("waitcmp_occupancy", int'(sif.occupancy),   4);
        check("waitcmp_valid",     int'(sif.issue_valid), 1);
        check("waitcmp_index",     int'(sif.issue_index), 4);
        alloc(16'h0001);
        check("reuse2_oldest", int'(sif.issue_index), 4);
        exp_q.push_back(4);
        sif.issue_ready = 1'b1;
        tick();
        sif.issue_ready = 1'b0;
        check("slot2_blocked", int'(sif.issue_valid), 0);
        exp_q.push_back(2);
        sif.issue_ready = 1'b1;
        complete(0);
        tick();
        sif.issue_ready = 1'b0;
        check("end_valid",     int'(sif.issue_valid), 0);
        check("end_occupancy", int'(sif.occupancy),   4);
        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
